// File: rtl/multiply_iter.sv
// multiply_iter: row-serial multiplier. Each cycle one A word is multiplied by all B words.
// The low and high slices of every product are summed into 2*NUM_ELEMENTS binary column sums.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready with the A and B word arrays;
//        out_valid/out_ready with the COL column sums; acc_en exists only when
//        MULTIPLY_ITER_ACCUM_EN is defined (acc_en=1 adds the next job onto the held sums).
// Latency: N+1 cycles from acceptance to out_valid. COL is held through DONE until out_ready.
module multiply_iter #(
  parameter int NUM_ELEMENTS    = 8,
  parameter int A_BIT_LEN       = 17,
  parameter int B_BIT_LEN       = 17,
  parameter int WORD_LEN        = 16,
  parameter int MUL_OUT_BIT_LEN = A_BIT_LEN + B_BIT_LEN,
  parameter int COL_BIT_LEN     = MUL_OUT_BIT_LEN - WORD_LEN,
  parameter int OUT_BIT_LEN     = COL_BIT_LEN + $clog2(2*NUM_ELEMENTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef MULTIPLY_ITER_ACCUM_EN
  input  logic                   acc_en,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [A_BIT_LEN-1:0]   A   [NUM_ELEMENTS],
  input  logic [B_BIT_LEN-1:0]   B   [NUM_ELEMENTS],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_BIT_LEN-1:0] COL [2*NUM_ELEMENTS]
);

  localparam int N     = NUM_ELEMENTS;
  localparam int NC    = 2 * NUM_ELEMENTS;
  localparam int CNT_W = $clog2(NUM_ELEMENTS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           row_cnt;
  logic [CNT_W-1:0]           prod_row;
  logic                       prod_vld;
  logic [A_BIT_LEN-1:0]       a_reg    [N];
  logic [B_BIT_LEN-1:0]       b_reg    [N];
  logic [MUL_OUT_BIT_LEN-1:0] prod_nxt [N];
  logic [MUL_OUT_BIT_LEN-1:0] prod     [N];
  logic [OUT_BIT_LEN-1:0]     col_q    [NC];
  logic [OUT_BIT_LEN-1:0]     col_nxt  [NC];
  logic                       take;
  logic                       clear_cols;

  // in_ready is gated by rst_n so that nothing is offered while reset is asserted.
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign take      = in_valid && in_ready;
  assign COL       = col_q;

`ifdef MULTIPLY_ITER_ACCUM_EN
  assign clear_cols = !acc_en;
`else
  assign clear_cols = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = RUN;
      RUN:     if (row_cnt == CNT_W'(N-1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One row of products per cycle: A[row_cnt] times every B word.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      prod_nxt[j] = MUL_OUT_BIT_LEN'(a_reg[row_cnt]) * MUL_OUT_BIT_LEN'(b_reg[j]);
    end
  end

  // Row r adds its low slices to columns r+j and its high slices to columns r+j+1.
  // The adds are written per column with constant indices, so each column gets its own
  // small adder tree and no variable-index write port is needed.
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      col_nxt[c] = col_q[c];
      if (prod_vld) begin
        for (int j = 0; j < N; j++) begin
          if (int'(prod_row) + j == c)
            col_nxt[c] = col_nxt[c] + OUT_BIT_LEN'(prod[j][WORD_LEN-1:0]);
          if (int'(prod_row) + j + 1 == c)
            col_nxt[c] = col_nxt[c] + OUT_BIT_LEN'(prod[j][MUL_OUT_BIT_LEN-1:WORD_LEN]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      prod_row <= '0;
      prod_vld <= 1'b0;
      a_reg    <= '{default: '0};
      b_reg    <= '{default: '0};
      prod     <= '{default: '0};
      col_q    <= '{default: '0};
    end else begin
      if (take) begin
        a_reg   <= A;
        b_reg   <= B;
        row_cnt <= '0;
      end
      prod_vld <= (state == RUN);
      if (state == RUN) begin
        prod     <= prod_nxt;
        prod_row <= row_cnt;
        row_cnt  <= row_cnt + CNT_W'(1);
      end
      // The product register is never valid in IDLE, so a clear cannot collide with an add.
      if (take && clear_cols) col_q <= '{default: '0};
      else                    col_q <= col_nxt;
    end
  end

endmodule

// File: tb/tb_multiply_iter.sv
module tb_multiply_iter;

  localparam int N  = 4;
  localparam int AW = 17;
  localparam int OW = 21;

  typedef logic [N-1:0][AW-1:0]   ops_t;
  typedef logic [2*N-1:0][OW-1:0] cols_t;
  typedef struct {
    ops_t  a;
    ops_t  b;
    cols_t col;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          acc_en = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] A   [N];
  logic [AW-1:0] B   [N];
  logic [OW-1:0] COL [2*N];

  int    total = 0;
  int    bad = 0;
  cols_t exp_q[$];

  always #5 clk = ~clk;

  multiply_iter #(
    .NUM_ELEMENTS(N), .A_BIT_LEN(AW), .B_BIT_LEN(AW), .WORD_LEN(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MULTIPLY_ITER_ACCUM_EN
    .acc_en(acc_en),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .COL(COL)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic cols_t get_col();
    cols_t r;
    for (int i = 0; i < 2*N; i++) r[i] = COL[i];
    return r;
  endfunction

  // Reference: every product split into 16-bit low slice and high slice.
  function automatic cols_t model(input ops_t a, input ops_t b);
    cols_t c;
    logic [33:0] p;
    c = '0;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        p = 34'(a[r]) * 34'(b[j]);
        c[r+j]   = c[r+j]   + OW'(p[15:0]);
        c[r+j+1] = c[r+j+1] + OW'(p[33:16]);
      end
    return c;
  endfunction

  // Independent check: sum COL[c]*2^(16c) equals (sum A[i]*2^(16i)) * (sum B[j]*2^(16j)).
  function automatic logic [255:0] poly_ops(input ops_t x);
    logic [255:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + (256'(x[i]) << (16*i));
    return s;
  endfunction

  function automatic logic [255:0] poly_cols(input cols_t x);
    logic [255:0] s;
    s = '0;
    for (int i = 0; i < 2*N; i++) s = s + (256'(x[i]) << (16*i));
    return s;
  endfunction

  task automatic drive_ops(input ops_t a, input ops_t b);
    for (int i = 0; i < N; i++) begin
      A[i] = a[i];
      B[i] = b[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      A[i] = AW'($urandom);
      B[i] = AW'($urandom);
    end
  endtask

  // Called at the negedge right after the acceptance edge; waits for DONE and scores it.
  task automatic wait_result(input string tag, input ops_t a, input ops_t b, input bit ident);
    int    lat;
    cols_t want;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 256'(lat), 256'(N+1));
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check({tag, " col"}, get_col(), want);
    end else begin
      check({tag, " scoreboard"}, 256'(0), 256'(1));
    end
    if (ident) check({tag, " identity"}, poly_cols(get_col()), poly_ops(a) * poly_ops(b));
    check({tag, " in_ready in done"}, 256'(in_ready), 256'(0));
  endtask

  task automatic run_job(input string tag, input ops_t a, input ops_t b, input cols_t want,
                         input logic acc, input bit ident);
    @(negedge clk);
    check({tag, " in_ready idle"}, 256'(in_ready), 256'(1));
    drive_ops(a, b);
    acc_en   = acc;
    in_valid = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(want);
    @(negedge clk);
    in_valid = 1'b0;
    acc_en   = ~acc;
    rand_ops();
    wait_result(tag, a, b, ident);
    @(negedge clk);
    check({tag, " out_valid drop"}, 256'(out_valid), 256'(0));
    check({tag, " in_ready back"}, 256'(in_ready), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[3];
    ops_t  ones, maxo, ra, rb;
    cols_t ones_col, snap;
    bit    ov_ok, col_ok, rdy_ok;

    for (int i = 0; i < N; i++) begin
      ones[i] = 17'd1;
      maxo[i] = 17'h1FFFF;
    end
    ones_col = {21'd0, 21'd1, 21'd2, 21'd3, 21'd4, 21'd3, 21'd2, 21'd1};
    vecs[0].a = ones; vecs[0].b = ones; vecs[0].col = ones_col;
    vecs[1].a = maxo; vecs[1].b = maxo;
    vecs[1].col = {21'd262140, 21'd524281, 21'd786422, 21'd1048563,
                   21'd786424, 21'd524283, 21'd262142, 21'd1};
    vecs[2].a = {17'd0, 17'd0, 17'd0, 17'd2};
    vecs[2].b = {17'h10000, 17'd0, 17'd5, 17'd3};
    vecs[2].col = {21'd0, 21'd0, 21'd0, 21'd2, 21'd0, 21'd0, 21'd10, 21'd6};

    // Reset with random inputs.
    rand_ops();
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out_valid", 256'(out_valid), 256'(0));
    check("reset in_ready", 256'(in_ready), 256'(0));
    check("reset col", get_col(), 256'(0));
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", 256'(in_ready), 256'(1));

    for (int v = 0; v < 3; v++) begin
      run_job($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].col, 1'b0, 1'b1);
    end

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = AW'($urandom);
        rb[i] = AW'($urandom);
      end
      run_job($sformatf("rand%0d", k), ra, rb, model(ra, rb), 1'b0, 1'b1);
    end

    // Backpressure: hold DONE for 20 cycles with a new job waiting at the input.
    @(negedge clk);
    out_ready = 1'b0;
    drive_ops(ones, ones);
    in_valid = 1'b1;
    exp_q.push_back(ones_col);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("bp first", ones, ones, 1'b1);
    snap = get_col();
    drive_ops(maxo, maxo);
    in_valid = 1'b1;
    ov_ok = 1'b1; col_ok = 1'b1; rdy_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1) ov_ok = 1'b0;
      if (get_col() !== snap) col_ok = 1'b0;
      if (in_ready !== 1'b0) rdy_ok = 1'b0;
    end
    check("bp out_valid held", 256'(ov_ok), 256'(1));
    check("bp col held", 256'(col_ok), 256'(1));
    check("bp in_ready low", 256'(rdy_ok), 256'(1));
    out_ready = 1'b1;
    exp_q.push_back(vecs[1].col);
    @(negedge clk);
    check("bp single handshake", 256'(out_valid), 256'(0));
    check("bp ready for pending", 256'(in_ready), 256'(1));
    @(negedge clk);
    check("bp pending accepted", 256'(in_ready), 256'(0));
    in_valid = 1'b0;
    wait_result("bp second", maxo, maxo, 1'b1);
    @(negedge clk);

    // Reset while row counter is 2.
    @(negedge clk);
    drive_ops(maxo, maxo);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst col", get_col(), 256'(0));
    check("midrst out_valid", 256'(out_valid), 256'(0));
    check("midrst in_ready", 256'(in_ready), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ov_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_ok = 1'b0;
    end
    check("midrst no out_valid", 256'(ov_ok), 256'(0) | 256'(1));
    check("midrst in_ready", 256'(in_ready), 256'(1));
    run_job("midrst ones", ones, ones, ones_col, 1'b0, 1'b1);

`ifdef MULTIPLY_ITER_ACCUM_EN
    run_job("acc0", ones, ones, ones_col, 1'b0, 1'b1);
    run_job("acc1", ones, ones, {21'd0, 21'd2, 21'd4, 21'd6, 21'd8, 21'd6, 21'd4, 21'd2},
            1'b1, 1'b0);
    run_job("acc restore", ones, ones, ones_col, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
